// File: rtl/panel_pkg.sv
// Shared constants and helpers for the front-panel controller.
// Optional build macro used elsewhere: LEADING_ZERO_BLANK_EN.
package panel_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REFRESH_CYCLES  = 5000000;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/front_panel_ctrl_if.sv
// Front-panel signal bundle: board side (master) and controller side (slave).
interface front_panel_ctrl_if
    import panel_pkg::*;
#(
    parameter int NUM_KEYS   = 4,
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8
);

    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_KEYS-1:0]          key_raw_n;
    logic [NUM_CH*DATA_W-1:0]     ch_data;
    logic                         freeze;
    logic [NUM_KEYS-1:0]          key_level;
    logic [NUM_KEYS-1:0]          key_press;
    logic [CH_W-1:0]              ch_sel;
    logic [NUM_DIGITS*SEG_W-1:0]  hex_seg;

    modport master (
        output key_raw_n, ch_data, freeze,
        input  key_level, key_press, ch_sel, hex_seg
    );

    modport slave (
        input  key_raw_n, ch_data, freeze,
        output key_level, key_press, ch_sel, hex_seg
    );

endinterface

// File: rtl/SevenSegmentDigit.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module SevenSegmentDigit (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] pat;

    always_comb begin
        pat = 7'h7F;
        unique case (digit)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            4'hF: pat = 7'h0E;
        endcase
    end

    assign seg = blank ? 7'h7F : pat;

endmodule

// File: rtl/key_debounce.sv
// One push button: 2-FF synchroniser, stability counter, press pulse.
module key_debounce
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = ch_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = raw_n;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        cnt_d        = '0;
        // Count only consecutive mismatching cycles; any match restarts
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level = ~stable_q;
    assign press = stable_dly_q & ~stable_q;

endmodule

// File: rtl/front_panel_ctrl.sv
// Front-panel controller: key debounce, channel paging, hex snapshot display.
// Build macro LEADING_ZERO_BLANK_EN blanks digits above the top nonzero nibble.
module front_panel_ctrl
    import panel_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_CH          = 4,
    parameter int DATA_W          = 32,
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REFRESH_CYCLES  = DEF_REFRESH_CYCLES,
    parameter int NEXT_KEY        = 1,
    parameter int PREV_KEY        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    front_panel_ctrl_if.slave pif
);

    localparam int CH_W   = ch_width(NUM_CH);
    localparam int RCNT_W = ch_width(REFRESH_CYCLES);
    localparam int DISP_W = NIBBLE_W * NUM_DIGITS;
    localparam int CP_W   = (DATA_W < DISP_W) ? DATA_W : DISP_W;

    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [RCNT_W-1:0] R_LAST  = RCNT_W'(REFRESH_CYCLES - 1);

    logic [CH_W-1:0]       ch_sel_q, ch_sel_d;
    logic                  load_q, load_d;
    logic [RCNT_W-1:0]     rcnt_q, rcnt_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic                  step_next, step_prev;
    logic                  rcnt_term;
    logic [DATA_W-1:0]     chan_sel;
    logic [DISP_W-1:0]     disp_ext;
    logic [NUM_DIGITS-1:0] blank;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_n (pif.key_raw_n[i]),
            .level (pif.key_level[i]),
            .press (pif.key_press[i])
        );
    end

    assign step_next = pif.key_press[NEXT_KEY] & ~pif.key_press[PREV_KEY];
    assign step_prev = pif.key_press[PREV_KEY] & ~pif.key_press[NEXT_KEY];
    assign rcnt_term = (rcnt_q == R_LAST);

    always_comb begin
        chan_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel_q == CH_W'(c)) begin
                chan_sel = pif.ch_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign disp_ext = DISP_W'(chan_sel[CP_W-1:0]);

    always_comb begin
        ch_sel_d = ch_sel_q;
        if (NUM_CH > 1) begin
            if (step_next) begin
                ch_sel_d = (ch_sel_q == CH_LAST) ? '0
                                                 : ch_sel_q + CH_W'(1);
            end else if (step_prev) begin
                ch_sel_d = (ch_sel_q == '0) ? CH_LAST
                                            : ch_sel_q - CH_W'(1);
            end
        end
        load_d = (ch_sel_d != ch_sel_q);

        rcnt_d = rcnt_q + RCNT_W'(1);
        if (load_d || rcnt_term) begin
            rcnt_d = '0;
        end

        // A page change overrides freeze so the new channel shows at once
        disp_d = disp_q;
        if (load_q) begin
            disp_d = disp_ext;
        end else if (rcnt_term && !pif.freeze) begin
            disp_d = disp_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_sel_q <= '0;
            load_q   <= 1'b0;
            rcnt_q   <= '0;
            disp_q   <= '0;
        end else begin
            ch_sel_q <= ch_sel_d;
            load_q   <= load_d;
            rcnt_q   <= rcnt_d;
            disp_q   <= disp_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            seen     = seen | (|disp_q[k*NIBBLE_W +: NIBBLE_W]);
            blank[k] = ~seen;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        SevenSegmentDigit u_seg (
            .digit (disp_q[k*NIBBLE_W +: NIBBLE_W]),
            .blank (blank[k]),
            .seg   (pif.hex_seg[k*SEG_W +: SEG_W])
        );
    end

    assign pif.ch_sel = ch_sel_q;

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Bench for front_panel_ctrl: cycle model plus directed literal checks.
module tb_front_panel_ctrl;
    import panel_pkg::*;

    localparam int NK  = 4;
    localparam int NC  = 3;
    localparam int DW  = 32;
    localparam int ND  = 8;
    localparam int DB  = 4;
    localparam int RF  = 8;
    localparam int NXT = 1;
    localparam int PRV = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
    localparam logic [55:0] H0    = {{7{7'h7F}}, 7'h40};
    localparam logic [55:0] HA5   = {{6{7'h7F}}, 7'h08, 7'h12};
    localparam logic [55:0] HCAFE = {{4{7'h7F}}, 7'h46, 7'h08, 7'h0E, 7'h06};
`else
    localparam bit BLANK_EN = 1'b0;
    localparam logic [55:0] H0    = {8{7'h40}};
    localparam logic [55:0] HA5   = {{6{7'h40}}, 7'h08, 7'h12};
    localparam logic [55:0] HCAFE = {{4{7'h40}}, 7'h46, 7'h08, 7'h0E, 7'h06};
`endif
    localparam logic [55:0] H1234 = {7'h79, 7'h24, 7'h30, 7'h19,
                                     7'h12, 7'h02, 7'h78, 7'h00};
    localparam logic [55:0] HDEAD = {7'h21, 7'h06, 7'h08, 7'h21,
                                     7'h03, 7'h06, 7'h06, 7'h0E};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] raw_n = '1;
    logic          frz = 1'b0;
    logic [DW-1:0] dat [NC];
    int checks = 0;
    int errors = 0;

    front_panel_ctrl_if #(
        .NUM_KEYS(NK), .NUM_CH(NC), .DATA_W(DW), .NUM_DIGITS(ND)
    ) pif ();

    front_panel_ctrl #(
        .NUM_KEYS(NK), .NUM_CH(NC), .DATA_W(DW), .NUM_DIGITS(ND),
        .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF),
        .NEXT_KEY(NXT), .PREV_KEY(PRV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif)
    );

    assign pif.key_raw_n = raw_n;
    assign pif.freeze    = frz;
    assign pif.ch_data   = {dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Digits above the most significant nonzero nibble go dark when enabled
    function automatic logic [55:0] hex_exp(input logic [31:0] v);
        logic [55:0] r;
        int msd;
        msd = 0;
        r = '0;
        for (int i = 0; i < ND; i++) if (v[4*i +: 4] != 4'h0) msd = i;
        for (int k = 0; k < ND; k++)
            r[7*k +: 7] = (BLANK_EN && k > msd) ? 7'h7F : seg_of(v[4*k +: 4]);
        return r;
    endfunction

    function automatic int next_ch(input int ch, input logic n, input logic p);
        if (n && !p) return (ch + 1) % NC;
        if (p && !n) return (ch + NC - 1) % NC;
        return ch;
    endfunction

    function automatic logic [NK-1:0] pk(input logic a [NK]);
        logic [NK-1:0] r;
        for (int i = 0; i < NK; i++) r[i] = a[i];
        return r;
    endfunction

    // Behavioural model: raw delay line, run-length acceptance, page/refresh rules
    logic        m_s1 [NK];
    logic        m_s2 [NK];
    logic        m_acc [NK];
    logic        m_pulse [NK];
    int          m_age [NK];
    int          m_ch;
    logic [31:0] m_disp;
    int          m_tick;
    logic        m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NK; k++) begin
                m_s1[k] <= 1'b1; m_s2[k] <= 1'b1;
                m_acc[k] <= 1'b0; m_pulse[k] <= 1'b0; m_age[k] <= 0;
            end
            m_ch <= 0; m_disp <= '0; m_tick <= 0; m_pend <= 1'b0;
        end else begin
            for (int k = 0; k < NK; k++) begin
                m_s1[k] <= raw_n[k];
                m_s2[k] <= m_s1[k];
                if (!m_s2[k] != m_acc[k]) begin
                    if (m_age[k] + 1 >= DB) begin
                        m_acc[k] <= !m_s2[k];
                        m_pulse[k] <= !m_s2[k];
                        m_age[k] <= 0;
                    end else begin
                        m_age[k] <= m_age[k] + 1;
                        m_pulse[k] <= 1'b0;
                    end
                end else begin
                    m_age[k] <= 0;
                    m_pulse[k] <= 1'b0;
                end
            end
            if (next_ch(m_ch, m_pulse[NXT], m_pulse[PRV]) != m_ch) begin
                m_ch <= next_ch(m_ch, m_pulse[NXT], m_pulse[PRV]);
                m_tick <= 0;
                m_pend <= 1'b1;
            end else begin
                m_tick <= (m_tick + 1) % RF;
                m_pend <= 1'b0;
            end
            if (m_pend) m_disp <= dat[m_ch];
            else if (m_tick == RF - 1 && !frz) m_disp <= dat[m_ch];
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({pif.key_level, pif.key_press, pif.ch_sel, pif.hex_seg} !==
            {pk(m_acc), pk(m_pulse), 2'(m_ch), hex_exp(m_disp)}) begin
            errors++;
            $display("FAIL cycle t=%0t lvl=%b/%b prs=%b/%b ch=%0d/%0d hex=%h/%h",
                     $time, pif.key_level, pk(m_acc), pif.key_press,
                     pk(m_pulse), pif.ch_sel, m_ch, pif.hex_seg,
                     hex_exp(m_disp));
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [NK-1:0] m);
        tick(1);
        raw_n = raw_n & ~m;
        tick(8);
        raw_n = raw_n | m;
        tick(8);
    endtask

    task automatic count_pulses(input int key, input int win,
                                output int cnt, output int at);
        cnt = 0;
        at = 0;
        for (int n = 1; n <= win; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (pif.key_press[key]) begin
                cnt++;
                at = n;
            end
        end
    endtask

    initial begin
        int cnt, at;
        bit found;
        dat[0] = 32'h12345678;
        dat[1] = 32'h0000CAFE;
        dat[2] = 32'h000000A5;
        tick(3);
        @(negedge clk);
        check("rst_level", 64'(pif.key_level), 64'h0);
        check("rst_press", 64'(pif.key_press), 64'h0);
        check("rst_ch", 64'(pif.ch_sel), 64'h0);
        check("rst_hex", 64'(pif.hex_seg), 64'(H0));
        tick(1);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 3; i++) begin
            raw_n[1] = 1'b0; tick(2);
            raw_n[1] = 1'b1; tick(2);
        end
        raw_n[1] = 1'b0;
        count_pulses(1, 12, cnt, at);
        check("bounce_count", 64'(cnt), 64'd1);
        check("bounce_latency", 64'(at), 64'd6);
        check("bounce_level", 64'(pif.key_level[1]), 64'd1);
        tick(1);
        raw_n[1] = 1'b1;
        count_pulses(1, 12, cnt, at);
        check("release_pulses", 64'(cnt), 64'd0);
        check("release_level", 64'(pif.key_level[1]), 64'd0);
        check("bounce_ch", 64'(pif.ch_sel), 64'd1);

        tick(1);
        raw_n[0] = 1'b0;
        tick(4);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_level", 64'(pif.key_level[0]), 64'd0);
        check("midrst_press", 64'(pif.key_press[0]), 64'd0);
        tick(2);
        rst_n = 1'b1;
        count_pulses(0, 10, cnt, at);
        check("rerst_count", 64'(cnt), 64'd1);
        check("rerst_latency", 64'(at), 64'd6);
        tick(1);
        raw_n[0] = 1'b1;
        tick(10);

        press(4'b0010); @(negedge clk); check("page_n1", 64'(pif.ch_sel), 64'd1);
        press(4'b0010); @(negedge clk); check("page_n2", 64'(pif.ch_sel), 64'd2);
        press(4'b0010); @(negedge clk); check("page_n3", 64'(pif.ch_sel), 64'd0);
        press(4'b0100); @(negedge clk); check("page_prev", 64'(pif.ch_sel), 64'd2);
        press(4'b0110); @(negedge clk); check("page_both", 64'(pif.ch_sel), 64'd2);

        press(4'b0010);
        @(negedge clk);
        check("ref_ch0", 64'(pif.ch_sel), 64'd0);
        check("ref_initial", 64'(pif.hex_seg), 64'(H1234));
        dat[0] = 32'hDEADBEEF;
        found = 1'b0;
        for (int n = 0; n < RF + 2 && !found; n++) begin
            @(negedge clk);
            if (pif.hex_seg === HDEAD) found = 1'b1;
        end
        check("ref_update", 64'(found), 64'd1);
        tick(1);
        dat[0] = 32'h12345678;
        found = 1'b0;
        for (int n = 0; n < RF + 2 && !found; n++) begin
            @(negedge clk);
            if (pif.hex_seg === H1234) found = 1'b1;
        end
        check("ref_back", 64'(found), 64'd1);
        tick(1);
        frz = 1'b1;
        dat[0] = 32'hDEADBEEF;
        tick(30);
        @(negedge clk);
        check("freeze_hold", 64'(pif.hex_seg), 64'(H1234));

        tick(1);
        raw_n[1] = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            if (pif.ch_sel == 2'd1) found = 1'b1;
        end
        check("frz_page_seen", 64'(found), 64'd1);
        @(negedge clk);
        check("frz_page_hex", 64'(pif.hex_seg), 64'(HCAFE));
        tick(1);
        raw_n[1] = 1'b1;
        tick(10);

        frz = 1'b0;
        press(4'b0010);
        @(negedge clk);
        check("blank_ch2", 64'(pif.ch_sel), 64'd2);
        check("blank_a5", 64'(pif.hex_seg), 64'(HA5));
        tick(1);
        dat[2] = 32'h0;
        tick(RF + 2);
        @(negedge clk);
        check("blank_zero", 64'(pif.hex_seg), 64'(H0));

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
